uart_rx_buffer: RTL and testbench
=================================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of byte entries; it must be a power of two, 2..256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the idle cycles before rx_timeout asserts; range 1..65535.
REQ-003 SHALL have port clock, input, 1 bit: the single CPU clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_valid, input, 1 bit: one-cycle strobe from the serial receiver that a byte is on rx_data.
REQ-006 SHALL have port rx_data, input, 8 bits: the received byte.
REQ-007 SHALL have port pop, input, 1 bit: CPU receive_flag, one-cycle request to consume the head byte.
REQ-008 SHALL have port clear_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-009 SHALL have port data_out, output, 8 bits: the head byte, first-word-fall-through; 0 when empty.
REQ-010 SHALL have port data_available, output, 1 bit: high when count is not 0.
REQ-011 SHALL have port count, output, log2(DEPTH)+1 bits: the number of stored bytes.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.
REQ-013 SHALL have port rx_timeout, output, 1 bit: the idle-timeout indication (see Configuration).

Function
REQ-014 SHALL write rx_data into the tail entry on a clock edge where rx_valid=1 and count<DEPTH; count, data_available and data_out are updated at that edge (one-cycle latency).
REQ-015 SHALL discard the byte and set overflow when rx_valid=1 and count=DEPTH with no pop in that cycle; stored contents are unchanged.
REQ-016 SHALL advance the head on an edge where pop=1 and count>0; data_out shows the next byte after that edge.
REQ-017 SHALL ignore pop when count=0: no pointer change, no flag, data_out stays 0.
REQ-018 SHALL handle rx_valid and pop together when full: the pop completes, the push is accepted, count stays DEPTH, and overflow is not set.
REQ-019 SHALL handle rx_valid and pop together when empty: the push is accepted, the pop is ignored (no bypass), and count becomes 1.
REQ-020 SHALL keep the read and write pointers modulo DEPTH, wrapping from DEPTH-1 to 0 with no gap or duplicate.
REQ-021 SHALL clear overflow on clear_ovf=1; if clear_ovf coincides with a new drop, set wins.
REQ-022 SHALL leave data_out, count and data_available as pure functions of the registered state, with no combinational path from rx_valid or pop.

Reset
REQ-023 SHALL asynchronously, on reset=1, zero both pointers, count, overflow, rx_timeout and the idle counter; data_out=0 and data_available=0.
REQ-024 SHALL apply reset mid-operation as above: any byte in flight in that cycle is lost, and storage contents need not be cleared.
REQ-025 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Configuration
REQ-026 SHALL, when macro UART_RX_TIMEOUT_EN is defined, keep a 16-bit idle counter.
- Counter clears on any accepted push, any accepted pop, or count=0.
- Otherwise it increments each cycle, saturating.
- rx_timeout asserts the cycle the counter reaches TIMEOUT_CYCLES and holds until the next push or pop, or until empty.
REQ-027 SHALL, when UART_RX_TIMEOUT_EN is undefined, omit the counter logic entirely and tie rx_timeout to 0.

Structure
REQ-028 SHALL place the defaults RXBUF_DEPTH_DEFAULT and RXBUF_TIMEOUT_DEFAULT and the byte width constant (8) in the shared package uart_pkg.
REQ-029 SHALL instantiate one sub-module, rxbuf_mem, holding DEPTH x 8 storage with synchronous write and asynchronous read; all control logic stays in uart_rx_buffer.

Verification
REQ-030 SHALL cover basic FIFO order: push 0x41, 0x42, 0x43, then pop three times -> data_out reads 0x41, 0x42, 0x43; data_available falls after the third pop; count goes 3,2,1,0.
REQ-031 SHALL cover overflow: push 17 bytes 0x00..0x10 with DEPTH=16 -> count=16 and overflow=1; 16 pops return 0x00..0x0F; clear_ovf -> overflow=0.
REQ-032 SHALL cover full plus simultaneous events: when full, rx_valid=1 with 0xAA and pop=1 together -> count stays 16, overflow stays 0, and 0xAA is returned last.
REQ-033 SHALL cover empty plus simultaneous events: when empty, rx_valid=1 with 0x55 and pop=1 together -> count=1 and data_out=0x55.
REQ-034 SHALL cover wrap-around: 40 interleaved push/pop pairs with incrementing data -> every byte is returned in order and count never exceeds 1.
REQ-035 SHALL cover reset and timeout: reset asserted with count=5 -> all outputs are 0 immediately, without waiting for a clock edge; with UART_RX_TIMEOUT_EN and TIMEOUT_CYCLES=8, one push then 8 idle cycles -> rx_timeout=1, and a pop -> rx_timeout=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared constants and types for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    localparam int RXBUF_DEPTH_DEFAULT   = 16;
    localparam int RXBUF_TIMEOUT_DEFAULT = 1024;
    localparam int BYTE_W                = 8;

    typedef logic [BYTE_W-1:0] rxByte_t;

endpackage

// File: rtl/rxbuf_mem.sv
// Purpose: DEPTH x 8 byte storage for the receive buffer, synchronous write / asynchronous read.
// Latency: write lands on the clock edge; read data follows rdAddr combinationally.
// Backpressure: none; the caller decides when a write is legal.
module rxbuf_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = RXBUF_DEPTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  rxByte_t                  wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output rxByte_t                  rdData
);

    rxByte_t store [DEPTH];

    // Storage is left unreset; the control logic never exposes an unwritten entry.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            store[wrAddr] <= wrData;
        end
    end

    assign rdData = store[rdAddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Purpose: first-word-fall-through byte FIFO between the serial receiver and the CPU, with optional
//          idle timeout (enabled by defining UART_RX_TIMEOUT_EN).
// Latency: a pushed byte is visible on data_out/count one cycle later; a pop shows the next byte one cycle later.
// Backpressure: none toward the receiver; bytes arriving while full (and not popped) are dropped and flag overflow.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH          = RXBUF_DEPTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = RXBUF_TIMEOUT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  rxByte_t                rx_data,
    input  logic                   pop,
    input  logic                   clear_ovf,
    output rxByte_t                data_out,
    output logic                   data_available,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   rx_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("uart_rx_buffer: DEPTH must be a power of two in 2..256");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
        $error("uart_rx_buffer: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [CW-1:0] countReg;
    logic          ovfReg;
    rxByte_t       headByte;

    logic isEmpty;
    logic isFull;
    logic popAcc;
    logic pushAcc;
    logic dropByte;

    assign isEmpty  = (countReg == '0);
    assign isFull   = (countReg == CW'(DEPTH));
    // A pop frees a slot in the same edge, so a full buffer still accepts a push alongside it.
    assign popAcc   = pop && !isEmpty;
    assign pushAcc  = rx_valid && (!isFull || popAcc);
    assign dropByte = rx_valid && isFull && !pop;

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            countReg <= '0;
        end else begin
            if (pushAcc) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (popAcc) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({pushAcc, popAcc})
                2'b10:   countReg <= countReg + CW'(1);
                2'b01:   countReg <= countReg - CW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovfReg <= 1'b0;
        end else if (dropByte) begin
            ovfReg <= 1'b1;
        end else if (clear_ovf) begin
            ovfReg <= 1'b0;
        end
    end

    rxbuf_mem #(
        .DEPTH (DEPTH)
    ) uMem (
        .clock  (clock),
        .wrEn   (pushAcc),
        .wrAddr (wrPtr),
        .wrData (rx_data),
        .rdAddr (rdPtr),
        .rdData (headByte)
    );

    assign data_out       = isEmpty ? '0 : headByte;
    assign data_available = !isEmpty;
    assign count          = countReg;
    assign overflow       = ovfReg;

`ifdef UART_RX_TIMEOUT_EN
    logic [15:0] idleCnt;

    // Count idle cycles while bytes sit unread; any traffic or an empty buffer restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idleCnt <= '0;
        end else if (pushAcc || popAcc || isEmpty) begin
            idleCnt <= '0;
        end else if (idleCnt != 16'hFFFF) begin
            idleCnt <= idleCnt + 16'd1;
        end
    end

    assign rx_timeout = (idleCnt >= 16'(TIMEOUT_CYCLES));
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Purpose: self-checking bench for uart_rx_buffer against a queue-based reference model.
// Latency: checks land 1 time unit after each rising edge, or immediately after an async reset.
// Backpressure: exercised by filling to DEPTH, overflowing, and mixing push/pop at random.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;
    localparam int TOUT  = 8;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       pop;
    logic       clear_ovf;
    logic [7:0] data_out;
    logic       data_available;
    logic [4:0] count;
    logic       overflow;
    logic       rx_timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue, sticky flag and idle-cycle tally.
    byte unsigned mq[$];
    bit           mOvf;
    int           mIdle;
    int           maxCnt;

    uart_rx_buffer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .pop            (pop),
        .clear_ovf      (clear_ovf),
        .data_out       (data_out),
        .data_available (data_available),
        .count          (count),
        .overflow       (overflow),
        .rx_timeout     (rx_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [7:0] expHead;
        expHead = (mq.size() != 0) ? mq[0] : 8'h00;
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".avail"}, 32'(data_available), 32'(mq.size() != 0));
        chk({tag, ".data"}, 32'(data_out), 32'(expHead));
        chk({tag, ".ovf"}, 32'(overflow), 32'(mOvf));
        chk({tag, ".tout"}, 32'(rx_timeout), 32'(TO_EN && (mIdle >= TOUT)));
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the model at the rising edge, then check.
    task automatic step(input bit v, input logic [7:0] d, input bit p, input bit c, input string tag);
        int  n;
        bit  popOk;
        bit  pushOk;
        rx_valid  = v;
        rx_data   = d;
        pop       = p;
        clear_ovf = c;
        @(posedge clock);
        n      = mq.size();
        popOk  = p && (n > 0);
        pushOk = v && ((n < DEPTH) || popOk);
        if (popOk) void'(mq.pop_front());
        if (pushOk) mq.push_back(d);
        if (v && !pushOk) mOvf = 1'b1;
        else if (c) mOvf = 1'b0;
        if (pushOk || popOk || n == 0) mIdle = 0;
        else if (mIdle < 65535) mIdle++;
        if (mq.size() > maxCnt) maxCnt = mq.size();
        #1;
        checkModel(tag);
        @(negedge clock);
        rx_valid  = 1'b0;
        pop       = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic modelReset();
        mq.delete();
        mOvf  = 1'b0;
        mIdle = 0;
    endtask

    // Assert reset between edges, check outputs before any clock edge, release before the next rising edge.
    task automatic asyncReset(input string tag);
        reset = 1'b1;
        #1;
        modelReset();
        chk({tag, ".count0"}, 32'(count), 32'd0);
        chk({tag, ".data0"}, 32'(data_out), 32'd0);
        chk({tag, ".avail0"}, 32'(data_available), 32'd0);
        chk({tag, ".ovf0"}, 32'(overflow), 32'd0);
        chk({tag, ".tout0"}, 32'(rx_timeout), 32'd0);
        #2;
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        pop       = 1'b0;
        clear_ovf = 1'b0;
        modelReset();
        #1;
        checkModel("por");
        @(negedge clock);
        reset = 1'b0;

        // Basic FIFO order.
        step(1, 8'h41, 0, 0, "push41");
        step(1, 8'h42, 0, 0, "push42");
        step(1, 8'h43, 0, 0, "push43");
        chk("order.cnt3", 32'(count), 32'd3);
        chk("order.head41", 32'(data_out), 32'h41);
        step(0, 8'h00, 1, 0, "pop1");
        chk("order.head42", 32'(data_out), 32'h42);
        chk("order.cnt2", 32'(count), 32'd2);
        step(0, 8'h00, 1, 0, "pop2");
        chk("order.head43", 32'(data_out), 32'h43);
        chk("order.cnt1", 32'(count), 32'd1);
        step(0, 8'h00, 1, 0, "pop3");
        chk("order.cnt0", 32'(count), 32'd0);
        chk("order.availLow", 32'(data_available), 32'd0);

        // Pop while empty is ignored.
        step(0, 8'h00, 1, 0, "popEmpty");
        chk("popEmpty.data0", 32'(data_out), 32'd0);

        // Overflow: 17 pushes into 16 entries.
        for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0, "fill17");
        chk("ovf.cnt16", 32'(count), 32'd16);
        chk("ovf.set", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf.drainHead", 32'(data_out), 32'(i));
            step(0, 8'h00, 1, 0, "drain16");
        end
        step(0, 8'h00, 0, 1, "clearOvf");
        chk("ovf.cleared", 32'(overflow), 32'd0);

        // Full: drop coinciding with clear keeps the flag, then simultaneous push+pop.
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, "fillFull");
        step(1, 8'hEE, 0, 1, "dropAndClear");
        chk("setWins", 32'(overflow), 32'd1);
        step(0, 8'h00, 0, 1, "clearAgain");
        step(1, 8'hAA, 1, 0, "fullPushPop");
        chk("fullPP.cnt16", 32'(count), 32'd16);
        chk("fullPP.noOvf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("fullPP.lastAA", 32'(data_out), 32'hAA);
            step(0, 8'h00, 1, 0, "drainFull");
        end

        // Empty: simultaneous push+pop does not bypass.
        step(1, 8'h55, 1, 0, "emptyPushPop");
        chk("emptyPP.cnt1", 32'(count), 32'd1);
        chk("emptyPP.data55", 32'(data_out), 32'h55);
        step(0, 8'h00, 1, 0, "emptyPP.pop");

        // Wrap-around with interleaved push/pop pairs.
        maxCnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1, 8'(8'h80 + k), 0, 0, "wrapPush");
            chk("wrap.head", 32'(data_out), 32'(8'(8'h80 + k)));
            step(0, 8'h00, 1, 0, "wrapPop");
        end
        chk("wrap.maxCnt1", 32'(maxCnt), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 5, "rand");
        end
        for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 1, "randDrain");

        // Asynchronous reset mid-operation with five bytes stored.
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, "preReset");
        chk("preReset.cnt5", 32'(count), 32'd5);
        asyncReset("midReset");
        step(1, 8'h3C, 0, 0, "postReset");
        chk("postReset.data", 32'(data_out), 32'h3C);
        step(0, 8'h00, 1, 0, "postReset.pop");

        // Idle timeout: one byte, eight idle cycles, then a pop clears it.
        step(1, 8'h77, 0, 0, "toPush");
        for (int i = 0; i < 7; i++) step(0, 8'h00, 0, 0, "toIdle");
        chk("tout.before", 32'(rx_timeout), 32'd0);
        step(0, 8'h00, 0, 0, "toIdle8");
        chk("tout.asserted", 32'(rx_timeout), 32'(TO_EN));
        step(0, 8'h00, 0, 0, "toHold");
        chk("tout.held", 32'(rx_timeout), 32'(TO_EN));
        step(0, 8'h00, 1, 0, "toPop");
        chk("tout.cleared", 32'(rx_timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
